// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration for the FPGA arithmetic blocks.
package fpga_cfg_pkg;

    localparam int FP_WIDTH       = 32;
    localparam int FP_QINT        = 15;
    localparam int FP_QFRAC       = 16;
    localparam int FP_DIV_LATENCY = 3;
    localparam int FP_SQRT_ITERS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        DIV_ISSUE,
        DIV_WAIT,
        DONE
    } sqrt_state_t;

endpackage

// File: rtl/fxDiv.sv
// Pipelined signed fixed-point divider: quot = num / den in Q format, saturated,
// valid LATENCY cycles after valid_in.
module fxDiv
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH   = fpga_cfg_pkg::FP_WIDTH,
    parameter int QINT    = fpga_cfg_pkg::FP_QINT,
    parameter int QFRAC   = fpga_cfg_pkg::FP_QFRAC,
    parameter int LATENCY = fpga_cfg_pkg::FP_DIV_LATENCY
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] num,
    input  logic signed [WIDTH-1:0] den,
    output logic                    valid_out,
    output logic signed [WIDTH-1:0] quot
);

    // Wide enough to hold num << QFRAC without overflow.
    localparam int EXT_W = WIDTH + QINT + QFRAC + 1;
    localparam logic signed [EXT_W-1:0] Q_MAX = {{(EXT_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] Q_MIN = ~Q_MAX;

    logic signed [EXT_W-1:0] num_ext, den_ext, quot_full;
    logic signed [WIDTH-1:0] quot_sat;
    logic        [LATENCY-1:0] vld_p;
    logic signed [WIDTH-1:0]   quot_p [LATENCY];

    function automatic logic signed [WIDTH-1:0] sat_q(input logic signed [EXT_W-1:0] v);
        if (v > Q_MAX) return Q_MAX[WIDTH-1:0];
        if (v < Q_MIN) return Q_MIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    assign num_ext   = {{(EXT_W-WIDTH){num[WIDTH-1]}}, num};
    assign den_ext   = {{(EXT_W-WIDTH){den[WIDTH-1]}}, den};
    assign quot_full = (den == '0) ? (num[WIDTH-1] ? Q_MIN : Q_MAX)
                                   : (num_ext <<< QFRAC) / den_ext;
    assign quot_sat  = sat_q(quot_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= valid_in;
            for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Stage boundary: quotient travels alongside vld_p without reset.
    always_ff @(posedge clk) begin
        quot_p[0] <= quot_sat;
        for (int i = 1; i < LATENCY; i++) quot_p[i] <= quot_p[i-1];
    end

    assign valid_out = vld_p[LATENCY-1];
    assign quot      = quot_p[LATENCY-1];

endmodule

// File: rtl/fx_sqrt_nr.sv
// Fixed-point square root by Newton-Raphson, x <- (x + a/x)/2, with a
// power-of-two seed from the radicand's leading one and early exit on convergence.
module fx_sqrt_nr
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH       = fpga_cfg_pkg::FP_WIDTH,
    parameter int QINT        = fpga_cfg_pkg::FP_QINT,
    parameter int QFRAC       = fpga_cfg_pkg::FP_QFRAC,
    parameter int DIV_LATENCY = fpga_cfg_pkg::FP_DIV_LATENCY,
    parameter int MAX_ITERS   = fpga_cfg_pkg::FP_SQRT_ITERS,
    parameter int TOL         = 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [WIDTH-1:0] a,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [WIDTH-1:0] sqrt_out,
    output logic             err_neg,
    output logic [3:0]       iters_used
);

    sqrt_state_t state, state_nxt;

    logic signed [WIDTH-1:0] a_reg, x, q, x_new, sqrt_r;
    logic signed [WIDTH:0]   sum_w, diff_w, absdiff_w;
    logic [3:0]              iter_cnt, iters_r;
    logic                    err_r, div_vld_in, div_vld_out, done_iter;

    function automatic int lead_one(input logic [WIDTH-1:0] v);
        int p;
        p = -1;
        for (int i = 0; i < WIDTH; i++) if (v[i]) p = i;
        return p;
    endfunction

    // 2^floor((p-QFRAC)/2) in Q format; >>> on int floors negative exponents.
    function automatic logic signed [WIDTH-1:0] seed_x(input logic signed [WIDTH-1:0] v);
        int e;
        logic signed [WIDTH-1:0] one;
        one = 1;
        e   = (lead_one(v) - QFRAC) >>> 1;
        return one << (QFRAC + e);
    endfunction

    // Keeps the estimate strictly positive so the next division is well defined.
    function automatic logic signed [WIDTH-1:0] clamp_pos(input logic signed [WIDTH:0] v);
        if (v <= 0) return WIDTH'(1);
        return v[WIDTH-1:0];
    endfunction

    assign sum_w     = {x[WIDTH-1], x} + {q[WIDTH-1], q};
    assign x_new     = clamp_pos(sum_w >>> 1);
    assign diff_w    = {x_new[WIDTH-1], x_new} - {x[WIDTH-1], x};
    assign absdiff_w = (diff_w < 0) ? -diff_w : diff_w;
    assign done_iter = (iter_cnt + 4'd1 == 4'(MAX_ITERS)) ||
                       (absdiff_w <= $signed((WIDTH+1)'(TOL)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (valid_in) state_nxt = (a[WIDTH-1] || a == '0) ? DONE : SEED;
            SEED:      state_nxt = DIV_ISSUE;
            DIV_ISSUE: state_nxt = DIV_WAIT;
            DIV_WAIT:  if (div_vld_out) state_nxt = done_iter ? DONE : DIV_ISSUE;
            DONE:      if (ready_out) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_in   = (state == IDLE);
        valid_out  = (state == DONE);
        div_vld_in = (state == DIV_ISSUE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            x        <= '0;
            iter_cnt <= '0;
            sqrt_r   <= '0;
            err_r    <= 1'b0;
            iters_r  <= '0;
        end else begin
            case (state)
                IDLE: if (valid_in) begin
                    a_reg    <= a;
                    x        <= '0;
                    iter_cnt <= '0;
                    sqrt_r   <= '0;
                    err_r    <= a[WIDTH-1];
                    iters_r  <= '0;
                end
                SEED: x <= seed_x(a_reg);
                DIV_WAIT: if (div_vld_out) begin
                    x        <= x_new;
                    iter_cnt <= iter_cnt + 4'd1;
                    if (done_iter) begin
                        sqrt_r  <= x_new;
                        iters_r <= iter_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sqrt_out   = sqrt_r;
    assign err_neg    = err_r;
    assign iters_used = iters_r;

    fxDiv #(
        .WIDTH   (WIDTH),
        .QINT    (QINT),
        .QFRAC   (QFRAC),
        .LATENCY (DIV_LATENCY)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (div_vld_in),
        .num       (a_reg),
        .den       (x),
        .valid_out (div_vld_out),
        .quot      (q)
    );

endmodule

// File: tb/tb_fx_sqrt_nr.sv
// Directed scoreboard bench for fx_sqrt_nr in Q15.16 with TOL=0, MAX_ITERS=4.
module tb_fx_sqrt_nr;

    localparam int LAT   = fpga_cfg_pkg::FP_DIV_LATENCY;
    localparam int ITERS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [31:0] a = '0;
    logic        valid_out;
    logic        ready_out = 1'b0;
    logic [31:0] sqrt_out;
    logic        err_neg;
    logic [3:0]  iters_used;

    typedef struct {
        string       tag;
        logic [31:0] sq;
        int          tol;
        logic        err;
        int          iters;   // -1: only bounded by ITERS
        int          lat;     // -1: not checked
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    fx_sqrt_nr #(
        .WIDTH(32), .QINT(15), .QFRAC(16), .DIV_LATENCY(LAT),
        .MAX_ITERS(ITERS), .TOL(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in), .a(a),
        .valid_out(valid_out), .ready_out(ready_out), .sqrt_out(sqrt_out),
        .err_neg(err_neg), .iters_used(iters_used)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol);
        int d;
        d = $signed(obs) - $signed(exp);
        if (d < 0) d = -d;
        if ($isunknown(obs)) d = tol + 1;
        n_cmp++;
        assert (d <= tol) else begin
            n_mis++;
            $error("FAIL %s observed=0x%08h expected=0x%08h+/-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] sq, input int tol,
                        input logic err, input int iters, input int lat);
        exp_t e;
        e.tag = tag; e.sq = sq; e.tol = tol; e.err = err; e.iters = iters; e.lat = lat;
        sb.push_back(e);
    endtask

    // Called at a negedge; drives one operand, waits for the result, holds it
    // for 'hold' cycles, completes the handshake and returns at a negedge.
    task automatic run_op(input logic [31:0] av, input int hold);
        exp_t        e;
        int          cyc;
        logic [31:0] s0;
        chk("ready_in_idle", {31'd0, ready_in}, 32'd1);
        valid_in = 1'b1;
        a        = av;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        a        = '0;
        cyc      = 1;
        while (valid_out !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        n_cmp++;
        assert (valid_out === 1'b1) else begin
            n_mis++;
            $error("FAIL %s.timeout observed=%0d cycles expected=valid_out", e.tag, cyc);
        end
        if (e.lat >= 0) chk({e.tag, ".latency"}, cyc, e.lat);
        chk_near({e.tag, ".sqrt"}, sqrt_out, e.sq, e.tol);
        chk({e.tag, ".err_neg"}, {31'd0, err_neg}, {31'd0, e.err});
        if (e.iters >= 0) begin
            chk({e.tag, ".iters"}, {28'd0, iters_used}, e.iters);
        end else begin
            n_cmp++;
            assert (!$isunknown(iters_used) && iters_used <= ITERS) else begin
                n_mis++;
                $error("FAIL %s.iters observed=%0d expected<=%0d", e.tag, iters_used, ITERS);
            end
        end
        s0 = sqrt_out;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({e.tag, ".hold_valid"}, {31'd0, valid_out}, 32'd1);
            chk({e.tag, ".hold_sqrt"}, sqrt_out, s0);
            chk({e.tag, ".hold_err"}, {31'd0, err_neg}, {31'd0, e.err});
            chk({e.tag, ".hold_ready_in"}, {31'd0, ready_in}, 32'd0);
        end
        ready_out = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready_out = 1'b0;
        chk({e.tag, ".post_valid"}, {31'd0, valid_out}, 32'd0);
        chk({e.tag, ".post_ready_in"}, {31'd0, ready_in}, 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst.sqrt_out", sqrt_out, 32'd0);
        chk("rst.err_neg", {31'd0, err_neg}, 32'd0);
        chk("rst.iters_used", {28'd0, iters_used}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.ready_in", {31'd0, ready_in}, 32'd1);

        // sqrt(4.0): exact seed, converges after one iteration; output held 10 cycles
        push("sqrt4", 32'h0002_0000, 1, 1'b0, 1, 2 + 1 * (LAT + 1));
        run_op(32'h0004_0000, 10);

        // Zero taken one cycle after the previous handshake
        push("zero", 32'h0, 0, 1'b0, 0, 1);
        run_op(32'h0000_0000, 0);

        push("neg", 32'h0, 0, 1'b1, 0, 1);
        run_op(32'hFFFF_0000, 0);

        // sqrt(2.0) runs the full iteration budget
        push("sqrt2", 32'h0001_6A0A, 2, 1'b0, ITERS, 2 + ITERS * (LAT + 1));
        run_op(32'h0002_0000, 0);

        // Reset while the divider is busy
        valid_in = 1'b1;
        a        = 32'h0009_0000;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        a        = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.valid_out", {31'd0, valid_out}, 32'd0);
        chk("midrst.sqrt_out", sqrt_out, 32'd0);
        chk("midrst.err_neg", {31'd0, err_neg}, 32'd0);
        chk("midrst.iters_used", {28'd0, iters_used}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst.ready_in", {31'd0, ready_in}, 32'd1);
        repeat (LAT + 2) @(negedge clk);
        chk("midrst.stale_valid", {31'd0, valid_out}, 32'd0);

        push("sqrt9", 32'h0003_0000, 1, 1'b0, -1, -1);
        run_op(32'h0009_0000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
